// File: rtl/store_module.sv
// ============================================================================
// Module      : store_module
// Description : MEM-stage store path; lane-aligns 1/2/4/8-byte stores onto a
//               64-bit write port, splitting 8-byte-crossing stores in two.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_module #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    store_valid,
    output logic                    store_ready,
    input  logic [ADDR_WIDTH-1:0]   store_address,
    input  logic [1:0]              store_size,
    input  logic [DATA_WIDTH-1:0]   store_data,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ack,
    output logic                    store_done,
    output logic                    store_stall
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_WIDTH-1:0]   hi_data_q, hi_data_d;
    logic [STRB_WIDTH-1:0]   hi_strb_q, hi_strb_d;
    logic                    store_done_q, store_done_d;

    logic [2:0]              off;
    logic [STRB_WIDTH-1:0]   size_mask;
    logic [DATA_WIDTH-1:0]   data_masked;
    logic [2*DATA_WIDTH-1:0] shifted;
    logic [2*STRB_WIDTH-1:0] strb;

    always_comb begin
        off = store_address[2:0];
        case (store_size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        for (int i = 0; i < STRB_WIDTH; i++) begin
            data_masked[8*i +: 8] = store_data[8*i +: 8] & {8{size_mask[i]}};
        end
        shifted = {{DATA_WIDTH{1'b0}}, data_masked} << {off, 3'b000};
        strb    = {{STRB_WIDTH{1'b0}}, size_mask} << off;

        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        hi_data_d    = hi_data_q;
        hi_strb_d    = hi_strb_q;
        store_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (store_valid) begin
                    state_d     = BEAT0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {store_address[ADDR_WIDTH-1:3], 3'b000};
                    mem_wdata_d = shifted[DATA_WIDTH-1:0];
                    mem_wstrb_d = strb[STRB_WIDTH-1:0];
                    hi_data_d   = shifted[2*DATA_WIDTH-1:DATA_WIDTH];
                    hi_strb_d   = strb[2*STRB_WIDTH-1:STRB_WIDTH];
                end
            end
            BEAT0: begin
                if (mem_ack) begin
                    // Any upper strobe bit means the store spilled into the next dword.
                    if (|hi_strb_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + ADDR_WIDTH'(8);
                        mem_wdata_d = hi_data_q;
                        mem_wstrb_d = hi_strb_q;
                    end else begin
                        state_d      = IDLE;
                        mem_req_d    = 1'b0;
                        mem_addr_d   = '0;
                        mem_wdata_d  = '0;
                        mem_wstrb_d  = '0;
                        store_done_d = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    store_done_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                mem_wstrb_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            hi_data_q    <= '0;
            hi_strb_q    <= '0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            hi_data_q    <= hi_data_d;
            hi_strb_q    <= hi_strb_d;
            store_done_q <= store_done_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign store_done  = store_done_q;
    assign store_ready = (state_q == IDLE);
    assign store_stall = (state_q != IDLE);

endmodule

`default_nettype wire
